inst_fetch_unit: RTL and testbench

- Requester side of the instruction cache read interface. Holds the fetch PC and drives the cache address with a read op.
- Captures the combinational read data into a small in-order queue and presents {pc, instruction} to decode with a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and reloading the PC. Sits between inst_cache and the decode stage.

---
 rtl/inst_fetch_unit_pkg.sv | 23 ++
 rtl/inst_fetch_unit_fetch_queue.sv | 78 +++++++
 rtl/inst_fetch_unit.sv | 105 ++++++++++
 tb/tb_inst_fetch_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit_pkg
// Description : Shared constants and types for the instruction fetch unit.
//               INST_CACHE_OFFSET is the default fetch PC out of reset.
//               INST_WORD_BYTES is the PC increment per fetched word.
//               FETCH_QUEUE_DEPTH is the default fetch queue depth.
//               fetch_entry_t is one queue entry: {pc, instruction}.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_unit_pkg;

    localparam logic [31:0] INST_CACHE_OFFSET = 32'h0000_0400;
    localparam int          INST_WORD_BYTES   = 4;
    localparam int          FETCH_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage : inst_fetch_unit_pkg
`default_nettype wire

// File: rtl/inst_fetch_unit_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit_fetch_queue
// Description : Synchronous in-order FIFO for fetched {pc, inst} entries.
//               Flush has priority over push and pop. The head is read
//               combinationally from the current read slot. It reads as 0
//               while the FIFO is empty.
// Ports       : clk   - clock
//               rst   - synchronous active-low reset
//               flush - clear pointers and occupancy
//               push  - write din at the tail (caller guarantees space)
//               pop   - retire the head (caller guarantees non-empty)
//               din   - entry to write
//               head  - current head entry, 0 when empty
//               count - current occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;

    // Storage carries no reset; stale contents are never visible because
    // the head is gated by occupancy.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers wrap naturally since DEPTH == 2**PTR_W.
            if (push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign count = r_count;

endmodule : inst_fetch_unit_fetch_queue
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit
// Description : Requester side of the instruction cache read port. Holds
//               the fetch PC and captures combinational cache read data into
//               an in-order queue. Presents {pc, inst} to decode with a
//               valid/ready handshake. A redirect flushes the queue and
//               reloads the PC.
// Ports       : clk            - clock
//               rst            - synchronous active-low reset
//               fetch_enable   - allow PC advance and queue push
//               redirect_valid - load redirect_pc and flush the queue
//               redirect_pc    - redirect target (bits [1:0] ignored)
//               mem_address    - cache address (the fetch PC)
//               mem_op_type    - always read (0)
//               mem_i_val      - always 0
//               mem_rdata      - cache data for mem_address, same cycle
//               out_valid      - queue head valid
//               out_ready      - decode accepts the head
//               out_inst       - head instruction, 0 when empty
//               out_pc         - head PC, 0 when empty
//               q_count        - queue occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = INST_CACHE_OFFSET,
    parameter int          QUEUE_DEPTH = FETCH_QUEUE_DEPTH,
    parameter int          QPTR_W      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_enable,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       mem_address,
    output logic              mem_op_type,
    output logic [31:0]       mem_i_val,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [31:0]       out_pc,
    output logic [QPTR_W:0]   q_count
);

    localparam logic [QPTR_W:0] C_DEPTH_CNT = (QPTR_W + 1)'(QUEUE_DEPTH);
    localparam logic [31:0]     C_PC_STEP   = 32'(INST_WORD_BYTES);

    logic [31:0]     r_pc;
    logic            w_pop;
    logic            w_push;
    fetch_entry_t    w_din;
    fetch_entry_t    w_head;
    logic [QPTR_W:0] w_count;
    logic            unused_redirect_lsbs;

    // A redirect cycle neither consumes the head nor captures data. A full
    // queue may still push when the head leaves in the same cycle.
    assign w_pop  = out_valid && out_ready && !redirect_valid;
    assign w_push = fetch_enable && !redirect_valid &&
                    ((w_count < C_DEPTH_CNT) || w_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= {redirect_pc[31:2], 2'b00};
        end else if (w_push) begin
            r_pc <= r_pc + C_PC_STEP;
        end
    end

    assign w_din.pc   = r_pc;
    assign w_din.inst = mem_rdata;

    inst_fetch_unit_fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .PTR_W (QPTR_W),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fetch_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .head  (w_head),
        .count (w_count)
    );

    assign mem_address = r_pc;
    assign mem_op_type = 1'b0;
    assign mem_i_val   = 32'h0;

    assign out_valid = (w_count != '0);
    assign out_inst  = w_head.inst;
    assign out_pc    = w_head.pc;
    assign q_count   = w_count;

    assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

endmodule : inst_fetch_unit
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_unit
// Description : Directed self-checking bench for inst_fetch_unit. The cache
//               is modelled as word = address ^ 32'hA5A5A5A5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

    localparam logic [31:0] C_RP  = 32'h0000_0400;
    localparam logic [31:0] C_KEY = 32'hA5A5_A5A5;

    logic        clk;
    logic        rst;
    logic        fetch_enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] mem_address;
    logic        mem_op_type;
    logic [31:0] mem_i_val;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [2:0]  q_count;

    int n_pass  = 0;
    int n_total = 0;

    inst_fetch_unit #(
        .RESET_PC    (C_RP),
        .QUEUE_DEPTH (4),
        .QPTR_W      (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_enable   (fetch_enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_address    (mem_address),
        .mem_op_type    (mem_op_type),
        .mem_i_val      (mem_i_val),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .q_count        (q_count)
    );

    assign mem_rdata = mem_address ^ C_KEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b0;
        fetch_enable   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        step();
        step();

        // Reset state
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(q_count), 32'd0);
        check("rst_addr", mem_address, C_RP);
        check("rst_inst", out_inst, 32'h0);
        check("rst_pc", out_pc, 32'h0);
        check("op_type", 32'(mem_op_type), 32'd0);
        check("i_val", mem_i_val, 32'h0);

        // Streaming, one instruction per cycle
        rst          = 1'b1;
        fetch_enable = 1'b1;
        out_ready    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_pc", out_pc, C_RP + 32'(4 * i));
            check("stream_inst", out_inst, (C_RP + 32'(4 * i)) ^ C_KEY);
            check("stream_count", 32'(q_count), 32'd1);
            check("stream_addr", mem_address, C_RP + 32'(4 * (i + 1)));
        end

        // Backpressure: queue fills and the PC stalls
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("full_count", 32'(q_count), 32'd4);
        check("full_addr", mem_address, 32'h0000_0418);
        check("full_head", out_pc, 32'h0000_0408);
        check("full_inst", out_inst, 32'h0000_0408 ^ C_KEY);

        // Full with a pop: push allowed, occupancy holds
        out_ready = 1'b1;
        step();
        check("fp_count", 32'(q_count), 32'd4);
        check("fp_head", out_pc, 32'h0000_040C);
        check("fp_addr", mem_address, 32'h0000_041C);
        step();
        check("fp2_count", 32'(q_count), 32'd4);
        check("fp2_head", out_pc, 32'h0000_0410);

        // Drain one to leave three entries
        fetch_enable = 1'b0;
        step();
        check("three_count", 32'(q_count), 32'd3);
        check("three_head", out_pc, 32'h0000_0414);

        // Redirect with unaligned target while decode is ready
        fetch_enable   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        check("redir_count", 32'(q_count), 32'd0);
        check("redir_valid", 32'(out_valid), 32'd0);
        check("redir_addr", mem_address, 32'h0000_0100);
        check("redir_inst", out_inst, 32'h0);
        step();
        check("redir_head", out_pc, 32'h0000_0100);
        check("redir_hinst", out_inst, 32'h0000_0100 ^ C_KEY);
        check("redir_count2", 32'(q_count), 32'd1);

        // Redirect near the top of the address space: PC wraps to 0
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        check("wrap_addr", mem_address, 32'hFFFF_FFF8);
        step();
        check("wrap_pc0", out_pc, 32'hFFFF_FFF8);
        step();
        check("wrap_pc1", out_pc, 32'hFFFF_FFFC);
        step();
        check("wrap_pc2", out_pc, 32'h0000_0000);
        check("wrap_inst2", out_inst, C_KEY);
        check("wrap_valid2", 32'(out_valid), 32'd1);
        check("wrap_addr2", mem_address, 32'h0000_0004);

        // Fill, then reset together with a redirect: reset wins
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("fill_count", 32'(q_count), 32'd4);
        rst            = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        out_ready      = 1'b1;
        step();
        check("rr_valid", 32'(out_valid), 32'd0);
        check("rr_count", 32'(q_count), 32'd0);
        check("rr_addr", mem_address, C_RP);
        rst            = 1'b1;
        redirect_valid = 1'b0;

        // Queue two entries, then drain with fetch disabled
        out_ready = 1'b0;
        step();
        step();
        check("two_count", 32'(q_count), 32'd2);
        check("two_head", out_pc, C_RP);
        fetch_enable = 1'b0;
        out_ready    = 1'b1;
        step();
        check("drain1_count", 32'(q_count), 32'd1);
        check("drain1_pc", out_pc, C_RP + 32'd4);
        check("drain1_addr", mem_address, C_RP + 32'd8);
        step();
        check("drain2_count", 32'(q_count), 32'd0);
        check("drain2_inst", out_inst, 32'h0);
        check("drain2_pc", out_pc, 32'h0);
        check("drain2_valid", 32'(out_valid), 32'd0);
        check("drain2_addr", mem_address, C_RP + 32'd8);
        step();
        check("idle_addr", mem_address, C_RP + 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_inst_fetch_unit
`default_nettype wire
